// File: rtl/tx_desc_pkg.sv
// rtl/tx_desc_pkg.sv - shared widths, per-flow state type and pointer helper
package tx_desc_pkg;

  localparam int FLOWS_DEF      = 4;
  localparam int DEPTH_DEF      = 8;
  localparam int DATA_WIDTH_DEF = 64;

  localparam int FLOW_W = $clog2(FLOWS_DEF);
  localparam int PTR_W  = $clog2(DEPTH_DEF);
  localparam int CNT_W  = PTR_W + 1;

  // Sized for the largest legal DEPTH (64) so one type serves every build
  localparam int PTR_MAX_W = 6;
  localparam int CNT_MAX_W = PTR_MAX_W + 1;

  typedef struct packed {
    logic [PTR_MAX_W-1:0] wr_ptr;
    logic [PTR_MAX_W-1:0] rd_ptr;
    logic [CNT_MAX_W-1:0] cnt;
  } flow_state_t;

  function automatic logic [PTR_MAX_W-1:0] ptr_inc(input logic [PTR_MAX_W-1:0] p,
                                                   input int depth);
    return (p + PTR_MAX_W'(1)) & PTR_MAX_W'(depth - 1);
  endfunction

endpackage

// File: rtl/tx_desc_sdp_ram.sv
// rtl/tx_desc_sdp_ram.sv - simple dual-port RAM, read-first, registered read port
module tx_desc_sdp_ram #(
  parameter int WIDTH = 64,
  parameter int WORDS = 32,
  localparam int AW   = $clog2(WORDS)
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [WORDS];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  // Output register holds its value between reads; only it is reset
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/tx_desc_buffer.sv
// rtl/tx_desc_buffer.sv - per-flow circular descriptor queues in one shared RAM
module tx_desc_buffer
  import tx_desc_pkg::*;
#(
  parameter int FLOWS      = FLOWS_DEF,
  parameter int DEPTH      = DEPTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int REFILL_THR = 4
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     WR,
  input  logic [$clog2(FLOWS)-1:0] WR_ADDR,
  input  logic [DATA_WIDTH-1:0]    WR_DATA,
  output logic [FLOWS-1:0]         WR_FULL,
  output logic [FLOWS-1:0]         DESC_REQ,
  input  logic                     DESC_READ,
  input  logic [$clog2(FLOWS)-1:0] DESC_ADDR,
  output logic [DATA_WIDTH-1:0]    DESC_DO,
  output logic                     DESC_DO_VLD,
  output logic [FLOWS-1:0]         DESC_EMPTY,
  input  logic [FLOWS-1:0]         CLEAR,
  output logic                     OVERFLOW,
  output logic                     UNDERFLOW,
  input  logic                     ERR_CLR
);

  localparam int FW     = $clog2(FLOWS);
  localparam int PW     = $clog2(DEPTH);
  localparam int ADDR_W = FW + PW;

  flow_state_t st     [FLOWS];
  flow_state_t st_nxt [FLOWS];

  logic [FLOWS-1:0] empty, full, wr_sel, rd_sel;
  logic wr_hit, wr_ok, ovf_set;
  logic rd_hit, rd_ok, udf_set;
  logic [ADDR_W-1:0] waddr, raddr;

  // Flags derive from the registered counters, so they move one cycle after the event
  always_comb begin
    empty    = '0;
    full     = '0;
    DESC_REQ = '0;
    for (int i = 0; i < FLOWS; i++) begin
      empty[i]    = (st[i].cnt == '0);
      full[i]     = (st[i].cnt == CNT_MAX_W'(DEPTH));
      DESC_REQ[i] = (st[i].cnt <= CNT_MAX_W'(REFILL_THR)) && !CLEAR[i];
    end
  end

  assign DESC_EMPTY = empty;
  assign WR_FULL    = full;

  // A flow under CLEAR swallows its accesses without raising error flags
  always_comb begin
    wr_hit  = WR && !CLEAR[WR_ADDR];
    wr_ok   = wr_hit && !full[WR_ADDR];
    ovf_set = wr_hit && full[WR_ADDR];
    rd_hit  = DESC_READ && !CLEAR[DESC_ADDR];
    rd_ok   = rd_hit && !empty[DESC_ADDR];
    udf_set = rd_hit && empty[DESC_ADDR];
    for (int i = 0; i < FLOWS; i++) begin
      wr_sel[i] = wr_ok && (WR_ADDR == FW'(i));
      rd_sel[i] = rd_ok && (DESC_ADDR == FW'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < FLOWS; i++) begin
      st_nxt[i] = st[i];
      if (CLEAR[i]) begin
        st_nxt[i] = '0;
      end else begin
        if (wr_sel[i]) st_nxt[i].wr_ptr = ptr_inc(st[i].wr_ptr, DEPTH);
        if (rd_sel[i]) st_nxt[i].rd_ptr = ptr_inc(st[i].rd_ptr, DEPTH);
        case ({wr_sel[i], rd_sel[i]})
          2'b10:   st_nxt[i].cnt = st[i].cnt + CNT_MAX_W'(1);
          2'b01:   st_nxt[i].cnt = st[i].cnt - CNT_MAX_W'(1);
          default: st_nxt[i].cnt = st[i].cnt;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < FLOWS; i++) st[i] <= '0;
      DESC_DO_VLD <= 1'b0;
      OVERFLOW    <= 1'b0;
      UNDERFLOW   <= 1'b0;
    end else begin
      for (int i = 0; i < FLOWS; i++) st[i] <= st_nxt[i];
      DESC_DO_VLD <= rd_ok;
      OVERFLOW    <= ovf_set | (OVERFLOW  & ~ERR_CLR);
      UNDERFLOW   <= udf_set | (UNDERFLOW & ~ERR_CLR);
    end
  end

  // RAM word address is {flow, ptr}
  assign waddr = (ADDR_W'(WR_ADDR)   << PW) | ADDR_W'(st[WR_ADDR].wr_ptr);
  assign raddr = (ADDR_W'(DESC_ADDR) << PW) | ADDR_W'(st[DESC_ADDR].rd_ptr);

  tx_desc_sdp_ram #(
    .WIDTH (DATA_WIDTH),
    .WORDS (FLOWS * DEPTH)
  ) u_ram (
    .CLK   (CLK),
    .rst_n (RESET),
    .we    (wr_ok),
    .waddr (waddr),
    .wdata (WR_DATA),
    .re    (rd_ok),
    .raddr (raddr),
    .rdata (DESC_DO)
  );

endmodule

// File: tb/tb_tx_desc_buffer.sv
// tb/tb_tx_desc_buffer.sv - directed scoreboard bench for tx_desc_buffer
module tb_tx_desc_buffer;

  localparam int FLOWS = 4;
  localparam int DEPTH = 8;
  localparam int DW    = 64;
  localparam int THR   = 4;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             WR;
  logic [1:0]       WR_ADDR;
  logic [DW-1:0]    WR_DATA;
  logic [FLOWS-1:0] WR_FULL;
  logic [FLOWS-1:0] DESC_REQ;
  logic             DESC_READ;
  logic [1:0]       DESC_ADDR;
  logic [DW-1:0]    DESC_DO;
  logic             DESC_DO_VLD;
  logic [FLOWS-1:0] DESC_EMPTY;
  logic [FLOWS-1:0] CLEAR;
  logic             OVERFLOW;
  logic             UNDERFLOW;
  logic             ERR_CLR;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mq [FLOWS][$];
  logic [DW-1:0] exp_q [$];
  logic m_ovf, m_udf;

  always #5 CLK = ~CLK;

  tx_desc_buffer #(
    .FLOWS(FLOWS), .DEPTH(DEPTH), .DATA_WIDTH(DW), .REFILL_THR(THR)
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .WR(WR), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_FULL(WR_FULL),
    .DESC_REQ(DESC_REQ), .DESC_READ(DESC_READ), .DESC_ADDR(DESC_ADDR),
    .DESC_DO(DESC_DO), .DESC_DO_VLD(DESC_DO_VLD), .DESC_EMPTY(DESC_EMPTY),
    .CLEAR(CLEAR), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW), .ERR_CLR(ERR_CLR)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input logic [FLOWS-1:0] clr);
    logic [FLOWS-1:0] e_empty, e_full, e_req;
    for (int f = 0; f < FLOWS; f++) begin
      e_empty[f] = (mq[f].size() == 0);
      e_full[f]  = (mq[f].size() == DEPTH);
      e_req[f]   = (mq[f].size() <= THR) && !clr[f];
    end
    chk("desc_empty", 64'(DESC_EMPTY), 64'(e_empty));
    chk("wr_full",    64'(WR_FULL),    64'(e_full));
    chk("desc_req",   64'(DESC_REQ),   64'(e_req));
    chk("overflow",   64'(OVERFLOW),   64'(m_ovf));
    chk("underflow",  64'(UNDERFLOW),  64'(m_udf));
  endtask

  // One clock of stimulus; the model decides acceptance from pre-edge occupancy
  task automatic step(input logic wr, input int wa, input logic [DW-1:0] wd,
                      input logic rd, input int ra,
                      input logic [FLOWS-1:0] clr, input logic ec);
    logic rd_ok, wr_ok;
    rd_ok = rd && !clr[ra] && (mq[ra].size() != 0);
    wr_ok = wr && !clr[wa] && (mq[wa].size() < DEPTH);
    m_ovf = (wr && !clr[wa] && (mq[wa].size() == DEPTH)) | (m_ovf & ~ec);
    m_udf = (rd && !clr[ra] && (mq[ra].size() == 0))     | (m_udf & ~ec);
    if (rd_ok) exp_q.push_back(mq[ra].pop_front());
    if (wr_ok) mq[wa].push_back(wd);
    for (int f = 0; f < FLOWS; f++) if (clr[f]) mq[f].delete();

    WR = wr; WR_ADDR = 2'(wa); WR_DATA = wd;
    DESC_READ = rd; DESC_ADDR = 2'(ra);
    CLEAR = clr; ERR_CLR = ec;
    @(posedge CLK);
    #1;
    chk("desc_do_vld", 64'(DESC_DO_VLD), 64'(rd_ok));
    if (DESC_DO_VLD && exp_q.size() > 0) chk("desc_do", DESC_DO, exp_q.pop_front());
    check_flags(clr);
    WR = 1'b0; DESC_READ = 1'b0; ERR_CLR = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    RESET = 1'b0; WR = 1'b0; WR_ADDR = '0; WR_DATA = '0;
    DESC_READ = 1'b0; DESC_ADDR = '0; CLEAR = '0; ERR_CLR = 1'b0;
    m_ovf = 1'b0; m_udf = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_vld", 64'(DESC_DO_VLD), 64'd0);
    chk("rst_do", DESC_DO, 64'd0);
    check_flags('0);
    RESET = 1'b1;

    // Fill flow 2, overflow it, then drain in order
    for (int i = 0; i < 8; i++) step(1'b1, 2, 64'hA0 + 64'(i), 1'b0, 0, '0, 1'b0);
    step(1'b1, 2, 64'hEE, 1'b0, 0, '0, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 0, '0, 1'b1, 2, '0, 1'b0);
    step(1'b0, 0, '0, 1'b0, 0, '0, 1'b1);

    // Interleaved flows 0 and 3
    step(1'b1, 0, 64'h10, 1'b0, 0, '0, 1'b0);
    step(1'b1, 3, 64'h30, 1'b0, 0, '0, 1'b0);
    step(1'b1, 0, 64'h11, 1'b0, 0, '0, 1'b0);
    step(1'b1, 3, 64'h31, 1'b0, 0, '0, 1'b0);
    step(1'b0, 0, '0, 1'b1, 3, '0, 1'b0);
    step(1'b0, 0, '0, 1'b1, 0, '0, 1'b0);
    step(1'b0, 0, '0, 1'b1, 3, '0, 1'b0);
    step(1'b0, 0, '0, 1'b1, 0, '0, 1'b0);

    // Flow 1 steady state at 3 entries with wrap-around
    for (int i = 0; i < 3; i++) step(1'b1, 1, 64'h100 + 64'(i), 1'b0, 0, '0, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 1, 64'h200 + 64'(i), 1'b1, 1, '0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 0, '0, 1'b1, 1, '0, 1'b0);

    // Underflow on empty flow 0, then clear it
    step(1'b0, 0, '0, 1'b1, 0, '0, 1'b0);
    step(1'b0, 0, '0, 1'b0, 0, '0, 1'b1);

    // Same-flow simultaneous read/write on an empty flow: read rejected
    step(1'b1, 3, 64'h3A, 1'b1, 3, '0, 1'b0);
    step(1'b0, 0, '0, 1'b1, 3, '0, 1'b1);

    // CLEAR of flow 2 beats a same-cycle write; flow 0 untouched
    step(1'b1, 0, 64'h50, 1'b0, 0, '0, 1'b0);
    step(1'b1, 0, 64'h51, 1'b0, 0, '0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 2, 64'hC0 + 64'(i), 1'b0, 0, '0, 1'b0);
    step(1'b1, 2, 64'hCF, 1'b1, 2, 4'b0100, 1'b0);
    step(1'b0, 0, '0, 1'b0, 0, 4'b0100, 1'b0);
    step(1'b0, 0, '0, 1'b1, 0, '0, 1'b0);
    step(1'b0, 0, '0, 1'b1, 0, '0, 1'b0);

    // Reset asserted mid-read of flow 1
    step(1'b1, 1, 64'h61, 1'b0, 0, '0, 1'b0);
    step(1'b1, 1, 64'h62, 1'b0, 0, '0, 1'b0);
    step(1'b0, 0, '0, 1'b1, 1, '0, 1'b0);
    DESC_READ = 1'b1; DESC_ADDR = 2'd1;
    #2;
    RESET = 1'b0;
    for (int f = 0; f < FLOWS; f++) mq[f].delete();
    exp_q.delete();
    m_ovf = 1'b0; m_udf = 1'b0;
    #1;
    chk("rst_mid_vld", 64'(DESC_DO_VLD), 64'd0);
    check_flags('0);
    DESC_READ = 1'b0;
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    step(1'b1, 1, 64'h77, 1'b0, 0, '0, 1'b0);
    step(1'b0, 0, '0, 1'b1, 1, '0, 1'b0);
    step(1'b0, 0, '0, 1'b0, 0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
